// File: rtl/decode_pipe_stage.sv
// RV32I/RV32E decode stage: register file, immediate generator and a registered ID/EX boundary.
// Optional feature macro: DECODE_WB_BYPASS_EN forwards the writeback port into same-cycle operand reads.
module decode_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_alu_op,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_illegal,
  output logic [2:0]      out_mem_funct3,
  output logic [1:0]      out_wb_sel
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam int         IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [2:0]      mem_funct3;
    logic [1:0]      wb_sel;
  } idex_t;

  function automatic logic [2:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_alu = ALU_SLL;
      3'b100:  f3_to_alu = ALU_XOR;
      3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_alu = ALU_OR;
      3'b111:  f3_to_alu = ALU_AND;
      default: f3_to_alu = ALU_ADD;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;

  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  logic        cls_ok;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        dec_alu_src;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic [2:0]  dec_alu_op;
  logic [1:0]  dec_wb_sel;
  logic [31:0] imm32;

  always_comb begin
    cls_ok        = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    use_rd        = 1'b0;
    dec_alu_src   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_wb_sel    = 2'b00;
    imm32         = '0;
    case (opcode)
      OPC_R: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
        cls_ok     = !(funct3 inside {3'b010, 3'b011}) &&
                     ((funct7 == F7_BASE) ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
        dec_alu_op = f3_to_alu(funct3, funct7 == F7_ALT);
      end
      OPC_I: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        dec_alu_src = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        // Upper immediate bits only carry meaning for the shift forms.
        cls_ok      = !(funct3 inside {3'b010, 3'b011}) &&
                      (funct3 != 3'b001 || funct7 == F7_BASE) &&
                      (funct3 != 3'b101 || funct7 == F7_BASE || funct7 == F7_ALT);
        dec_alu_op  = f3_to_alu(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
      end
      OPC_LOAD: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        dec_alu_src  = 1'b1;
        dec_mem_read = 1'b1;
        dec_wb_sel   = 2'b01;
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        cls_ok       = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        imm32         = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        cls_ok        = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_LUI: begin
        use_rd      = 1'b1;
        dec_alu_src = 1'b1;
        imm32       = {in_instr[31:12], 12'b0};
        cls_ok      = 1'b1;
      end
      default: cls_ok = 1'b0;
    endcase
  end

  logic regs_ok;
  logic legal;

  assign regs_ok = (!use_rs1 || {1'b0, f_rs1} < NREGS_L) &&
                   (!use_rs2 || {1'b0, f_rs2} < NREGS_L) &&
                   (!use_rd  || {1'b0, f_rd}  < NREGS_L);
  assign legal   = cls_ok && regs_ok;

  // Unused or illegal sources collapse to x0 so they never match a hazard.
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign rs1_idx = (legal && use_rs1) ? f_rs1 : 5'd0;
  assign rs2_idx = (legal && use_rs2) ? f_rs2 : 5'd0;
  assign rd_idx  = (legal && use_rd)  ? f_rd  : 5'd0;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;

  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (rs1_idx != 5'd0) rf_rs1 = rf_q[rs1_idx[IW-1:0]];
    if (rs2_idx != 5'd0) rf_rs2 = rf_q[rs2_idx[IW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < NREGS_L) begin
      rf_q[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  logic load_hit;
  logic wb_hit1;
  logic wb_hit2;
  logic hazard;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign load_hit = ex_load_valid && ex_load_rd != 5'd0 &&
                    (ex_load_rd == rs1_idx || ex_load_rd == rs2_idx);
  assign wb_hit1  = wb_en && wb_rd != 5'd0 && wb_rd == rs1_idx;
  assign wb_hit2  = wb_en && wb_rd != 5'd0 && wb_rd == rs2_idx;

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val = wb_hit1 ? wb_data : rf_rs1;
  assign rs2_val = wb_hit2 ? wb_data : rf_rs2;
  assign hazard  = in_valid && load_hit;
`else
  // Without the bypass a same-cycle write stalls one cycle and is read from the file afterwards.
  assign rs1_val = rf_rs1;
  assign rs2_val = rf_rs2;
  assign hazard  = in_valid && (load_hit || wb_hit1 || wb_hit2);
`endif

  idex_t dec_d;

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = in_pc;
    dec_d.illegal = !legal;
    if (legal) begin
      dec_d.rs1_data   = rs1_val;
      dec_d.rs2_data   = rs2_val;
      dec_d.imm        = XLEN'($signed(imm32));
      dec_d.rs1        = rs1_idx;
      dec_d.rs2        = rs2_idx;
      dec_d.rd         = rd_idx;
      dec_d.alu_op     = dec_alu_op;
      dec_d.alu_src    = dec_alu_src;
      dec_d.reg_write  = use_rd;
      dec_d.mem_read   = dec_mem_read;
      dec_d.mem_write  = dec_mem_write;
      dec_d.mem_funct3 = (dec_mem_read || dec_mem_write) ? funct3 : 3'b000;
      dec_d.wb_sel     = dec_wb_sel;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a held output stays stable until it is taken or flushed.
  logic  valid_q;
  idex_t idex_q;
  logic  advance;
  logic  accept;

  assign advance  = !valid_q || out_ready;
  assign in_ready = flush || (advance && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= accept;
      if (accept) idex_q <= dec_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = idex_q.pc;
  assign out_rs1_data   = idex_q.rs1_data;
  assign out_rs2_data   = idex_q.rs2_data;
  assign out_imm        = idex_q.imm;
  assign out_rs1        = idex_q.rs1;
  assign out_rs2        = idex_q.rs2;
  assign out_rd         = idex_q.rd;
  assign out_alu_op     = idex_q.alu_op;
  assign out_alu_src    = idex_q.alu_src;
  assign out_reg_write  = idex_q.reg_write;
  assign out_mem_read   = idex_q.mem_read;
  assign out_mem_write  = idex_q.mem_write;
  assign out_illegal    = idex_q.illegal;
  assign out_mem_funct3 = idex_q.mem_funct3;
  assign out_wb_sel     = idex_q.wb_sel;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Testbench for decode_pipe_stage: directed scenarios then randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_decode_pipe_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic [2:0]  f3;
    logic [1:0]  wb_sel;
  } rec_t;

  localparam int W = $bits(rec_t);

  logic clk;
  logic reset_n;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic flush;
  logic wb_en;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic ex_load_valid;
  logic [4:0] ex_load_rd;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [2:0] out_alu_op;
  logic out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_illegal;
  logic [2:0] out_mem_funct3;
  logic [1:0] out_wb_sel;

  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_rf [32];
  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  decode_pipe_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_op(out_alu_op),
    .out_alu_src(out_alu_src), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_illegal(out_illegal),
    .out_mem_funct3(out_mem_funct3), .out_wb_sel(out_wb_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic rec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    rec_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok, u1, u2, ud;
    r = '0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b0; u1 = 1'b0; u2 = 1'b0; ud = 1'b0;
    case (op)
      7'b0110011: begin
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1; ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: r.alu_op = 3'd0;
          {7'h20, 3'd0}: r.alu_op = 3'd1;
          {7'h00, 3'd1}: r.alu_op = 3'd5;
          {7'h00, 3'd4}: r.alu_op = 3'd4;
          {7'h00, 3'd5}: r.alu_op = 3'd6;
          {7'h20, 3'd5}: r.alu_op = 3'd7;
          {7'h00, 3'd6}: r.alu_op = 3'd3;
          {7'h00, 3'd7}: r.alu_op = 3'd2;
          default:       ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        u1 = 1'b1; ud = 1'b1; r.alu_src = 1'b1;
        r.imm = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'd0: begin ok = 1'b1; r.alu_op = 3'd0; end
          3'd4: begin ok = 1'b1; r.alu_op = 3'd4; end
          3'd6: begin ok = 1'b1; r.alu_op = 3'd3; end
          3'd7: begin ok = 1'b1; r.alu_op = 3'd2; end
          3'd1: begin ok = (f7 == 7'h00); r.alu_op = 3'd5; end
          3'd5: begin ok = (f7 == 7'h00) || (f7 == 7'h20); r.alu_op = (f7 == 7'h20) ? 3'd7 : 3'd6; end
          default: ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        u1 = 1'b1; ud = 1'b1; r.alu_src = 1'b1; r.mem_read = 1'b1; r.wb_sel = 2'b01; r.f3 = f3;
        r.imm = {{20{ins[31]}}, ins[31:20]};
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      end
      7'b0100011: begin
        u1 = 1'b1; u2 = 1'b1; r.alu_src = 1'b1; r.mem_write = 1'b1; r.f3 = f3;
        r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ok = (f3 <= 3'd2);
      end
      7'b0110111: begin
        ud = 1'b1; r.alu_src = 1'b1; ok = 1'b1;
        r.imm = {ins[31:12], 12'b0};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '0;
      r.illegal = 1'b1;
    end else begin
      r.rs1 = u1 ? ins[19:15] : 5'd0;
      r.rs2 = u2 ? ins[24:20] : 5'd0;
      r.rd  = ud ? ins[11:7]  : 5'd0;
      r.reg_write = ud;
    end
    r.pc = pc;
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && wb_en && wb_rd == idx) return wb_data;
    return ref_rf[idx];
  endfunction

  function automatic logic ref_hazard(input rec_t r);
    logic lh, wh;
    lh = ex_load_valid && ex_load_rd != 5'd0 && (ex_load_rd == r.rs1 || ex_load_rd == r.rs2);
    wh = !BYPASS && wb_en && wb_rd != 5'd0 && (wb_rd == r.rs1 || wb_rd == r.rs2);
    return in_valid && (lh || wh);
  endfunction

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 9))
      0, 1: return rtype(f7, rnd_reg(), rnd_reg(), 3'($urandom_range(0, 7)), rnd_reg());
      2, 3: return itype({f7, 5'($urandom_range(0, 31))}, rnd_reg(), 3'($urandom_range(0, 7)), rnd_reg(), 7'b0010011);
      4:    return itype(12'($urandom()), rnd_reg(), 3'($urandom_range(0, 7)), rnd_reg(), 7'b0000011);
      5:    return stype(12'($urandom()), rnd_reg(), rnd_reg(), 3'($urandom_range(0, 3)));
      6:    return {20'($urandom()), rnd_reg(), 7'b0110111};
      7:    return $urandom();
      default: return rtype(7'($urandom()), rnd_reg(), rnd_reg(), 3'($urandom_range(0, 7)), rnd_reg());
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic lv, input logic [4:0] lr, input logic ordy);
    rec_t r;
    logic held, adv, exp_rdy, acc;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = $urandom() & ~32'h3; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd; ex_load_valid = lv; ex_load_rd = lr; out_ready = ordy;
    #1;
    r = ref_decode(ins, in_pc);
    r.rs1_data = ref_read(r.rs1);
    r.rs2_data = ref_read(r.rs2);
    held = (exp_q.size() != 0);
    adv = !held || ordy;
    exp_rdy = fl || (adv && !ref_hazard(r));
    n_tests++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b (instr %h)", in_ready, exp_rdy, ins);
    end
    acc = v && exp_rdy && !fl;
    @(posedge clk);
    #1;
    if (fl && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(r);
    if (we && wr != 5'd0) ref_rf[wr] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_load_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset out_valid: got %b expected 0", out_valid);
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    rec_t act;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        n_tests++;
        if (out_valid !== (exp_q.size() != 0)) begin
          n_fail++;
          $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
        end
        if (out_valid === 1'b1 && exp_q.size() != 0) begin
          act = '{out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
                  out_alu_op, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                  out_illegal, out_mem_funct3, out_wb_sel};
          n_tests++;
          if (act !== exp_q[0]) begin
            n_fail++;
            $display("FAIL out_fields: got %h expected %h", act, exp_q[0]);
          end
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rec_t rst_act;
    reset_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_load_valid = 1'b0; ex_load_rd = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    rst_act = '{out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
                out_alu_op, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                out_illegal, out_mem_funct3, out_wb_sel};
    n_tests++;
    if (out_valid !== 1'b0 || rst_act !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid %b fields %h expected all zero", out_valid, rst_act);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    mon_en = 1'b1;

    step(1, itype(12'h000, 5'd5, 3'd0, 5'd6, 7'b0010011), 0, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 1, 5'd3, 32'h1234, 0, 0, 1);
    step(1, itype(12'hfff, 5'd3, 3'd0, 5'd4, 7'b0010011), 0, 0, 0, 0, 0, 0, 1);
    // load-use on x7: two stalled cycles then accepted
    step(1, rtype(7'h00, 5'd2, 5'd7, 3'd0, 5'd1), 0, 0, 0, 0, 1, 5'd7, 1);
    step(1, rtype(7'h00, 5'd2, 5'd7, 3'd0, 5'd1), 0, 0, 0, 0, 1, 5'd7, 1);
    step(1, rtype(7'h00, 5'd2, 5'd7, 3'd0, 5'd1), 0, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    // backpressure: SUB held for three cycles, XOR waits
    step(1, rtype(7'h20, 5'd2, 5'd3, 3'd0, 5'd5), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, rtype(7'h00, 5'd4, 5'd3, 3'd4, 5'd6), 0, 0, 0, 0, 0, 0, 0);
    step(1, rtype(7'h00, 5'd4, 5'd3, 3'd4, 5'd6), 0, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    // flush drops an offered store; then an illegal opcode
    step(1, stype(12'h010, 5'd4, 5'd3, 3'd2), 1, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h0000_007f, 0, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    // same-cycle write and read of x9
    step(1, rtype(7'h00, 5'd0, 5'd9, 3'd0, 5'd10), 0, 1, 5'd9, 32'h0000_00aa, 0, 0, 1);
    step(1, rtype(7'h00, 5'd0, 5'd9, 3'd0, 5'd10), 0, 0, 0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), rnd_reg(), $urandom(),
           $urandom_range(0, 3) == 0, rnd_reg(), $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, out_valid %b expected 0 pending, 0", exp_q.size(), out_valid);
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised RV32I/RV32E instruction-decode stage with an integrated register file, immediate generator and registered ID/EX pipeline boundary. It sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and detects load-use hazards. It takes an explicit writeback port and presents decoded controls, operands and an immediate to execute one cycle after acceptance.

## Interface
- XLEN, 32: datapath width (32 or 64).
- NREGS, 32: architectural registers (32 = RV32I, 16 = RV32E); index width fixed at 5 bits.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1  fetch handshake.
- in_pc  in  XLEN  PC of the instruction.
- in_instr  in  32  instruction word.
- flush  in  1  kill the held output and the offered input (branch redirect).
- wb_en, wb_rd, wb_data  in  1, 5, XLEN  register-file write port.
- ex_load_valid, ex_load_rd  in  1, 5  a load currently in EX and its destination.
- out_valid / out_ready  out / in  1  execute handshake.
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  operands and sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5  register indices.
- out_alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_illegal  out  1.
- out_mem_funct3  out  3  load/store size and sign, passed through.
- out_wb_sel  out  2  00 ALU, 01 memory.

## Operation
- Decoded classes:
  - R-type 0110011: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA. funct7 is 0000000, or 0100000 for SUB/SRA only.
  - I-ALU 0010011: ADDI/ANDI/ORI/XORI/SLLI/SRLI/SRAI, alu_src=1.
  - Load 0000011: funct3 ∈ {000,001,010,100,101}. mem_read=1, reg_write=1, wb_sel=01, ADD.
  - Store 0100011: funct3 ∈ {000,001,010}. mem_write=1, ADD, S-immediate.
  - LUI 0110111: rs1 forced to 0, ADD, U-immediate.
- Illegal encodings (any other opcode or funct3/funct7 combination, or any register index ≥ NREGS):
  - out_illegal=1.
  - reg_write, mem_read and mem_write forced to 0.
  - The instruction still flows with out_valid=1.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes occur at the clock edge when wb_en=1. All registers clear on reset.
- Hazard: asserted when in_valid & ex_load_valid & ex_load_rd≠0 & ex_load_rd matches a source register actually used by the instruction (rs2 unused for I-ALU, load and LUI).
- Transfer rules:
  - advance = !out_valid | out_ready.
  - in_ready = advance & !hazard.
  - Accept when in_valid & in_ready: pipeline register loads all decoded fields.
  - advance & !accept: out_valid clears (bubble).
  - !advance: all outputs hold unchanged.
- Flush has highest priority:
  - Next cycle out_valid=0.
  - The input offered in the flush cycle is consumed (in_ready=1) and discarded.

## Timing
- Reset: out_valid=0 and every out_* field 0; the register file is zero.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 instruction per cycle when there is no hazard and out_ready=1.
- Operands are sampled at accept. A later write does not update a held output.
- A load-use hazard stalls exactly as long as the hazard term stays high; a bubble is emitted each stalled cycle in which advance=1.
- Simultaneous flush and hazard: flush wins, input consumed.
- A write and a read of the same register in one cycle resolve per Configuration.
- reset_n asserted mid-stream: immediate async clear; in-flight instruction lost.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - When wb_en & wb_rd≠0 & wb_rd equals a used source, that operand is taken from wb_data in the same cycle.
  - No extra stall.
- Undefined:
  - The same condition adds to the hazard term, stalling one cycle.
  - The operand is read from the register file in the following cycle.

## Test plan
- Reset: after reset_n low then high, read rs1=5 → out_rs1_data=0, out_valid=0 until first accept.
- Write then read: wb x3=0x1234 then ADDI x4,x3,-1 → out_rs1_data=0x1234, out_imm=0xFFFFFFFF, alu_op=000, alu_src=1, one cycle after accept.
- Load-use: ex_load_valid=1, ex_load_rd=7, offer ADD x1,x7,x2 → in_ready=0, bubble emitted; ex_load_valid drops → accepted next cycle.
- Backpressure: out_ready=0 for 3 cycles with SUB held → outputs stable, in_ready=0; then out_ready=1 → the next instruction appears the following cycle.
- Flush: flush with a valid SW offered → SW dropped, out_valid=0 next cycle. Opcode 1111111 → out_illegal=1, reg_write=0.
- Same-cycle write/read of x9=0xAA:
  - Macro on: operand 0xAA, no stall.
  - Macro off: one-cycle stall, then operand 0xAA.
